if_fetch_unit: RTL

- Instruction-fetch stage directly downstream of the branch-resolution logic. It consumes the 2-bit PCSrc decision and the two candidate targets, and owns the architectural PC register.
- It runs a request/acknowledge handshake with instruction memory and presents fetched instructions to the IF/ID boundary through a single-entry valid/ready buffer.
- On a taken redirect it flushes wrong-path fetches.

---
 rtl/if_fetch_unit_pkg.sv | 23 ++
 rtl/if_fetch_unit_if.sv | 39 +++
 rtl/if_fetch_unit_buffer.sv | 35 +++
 rtl/if_fetch_unit.sv | 121 ++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared encodings for the instruction-fetch stage: next-PC select codes,
// fetch FSM states and the canonical NOP word.
package if_fetch_unit_pkg;

    // Matches the branch-control unit's PCSrc encoding
    localparam logic [1:0] PCSRC_INC   = 2'b00;
    localparam logic [1:0] PCSRC_BR    = 2'b01;
    localparam logic [1:0] PCSRC_ALU   = 2'b10;
    localparam logic [1:0] PCSRC_NOINC = 2'b11;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,
        FETCH_REQ  = 2'b01,
        FETCH_DROP = 2'b10
    } fetch_state_t;

    function automatic logic is_redirect(input logic [1:0] pcsrc);
        return (pcsrc == PCSRC_BR) || (pcsrc == PCSRC_ALU);
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/ack bus plus the IF/ID valid/ready boundary,
// seen from the fetch unit (master) and from memory/decode (slave).
interface if_fetch_unit_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int INST_WIDTH = 32
);
    logic                  IMemReq;
    logic [ADDR_WIDTH-1:0] IMemAddr;
    logic                  IMemAck;
    logic [INST_WIDTH-1:0] IMemRdata;

    logic                  IfReady;
    logic                  IfValid;
    logic [INST_WIDTH-1:0] IfInstr;
    logic [ADDR_WIDTH-1:0] IfPC;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemAck,
        input  IMemRdata,
        input  IfReady,
        output IfValid,
        output IfInstr,
        output IfPC
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemAck,
        output IMemRdata,
        output IfReady,
        input  IfValid,
        input  IfInstr,
        input  IfPC
    );

endinterface

// File: rtl/if_fetch_unit_buffer.sv
// Single-entry IF/ID holding register; a push in the same cycle as a pop
// replaces the entry, and a flush empties it regardless of the consumer.
module if_fetch_unit_buffer #(
    parameter int ADDR_WIDTH = 64,
    parameter int INST_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [INST_WIDTH-1:0] push_instr,
    input  logic [ADDR_WIDTH-1:0] push_pc,
    output logic                  valid,
    output logic [INST_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (push) begin
            valid <= 1'b1;
            instr <= push_instr;
            pc    <= push_pc;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the req/ack handshake with
// instruction memory and squashes wrong-path fetches on a redirect.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            PCSrc,
    input  logic [ADDR_WIDTH-1:0] BrTarget,
    input  logic [ADDR_WIDTH-1:0] AluTarget,
    if_fetch_unit_if.master       bus,
    output logic                  Flush,
    output logic                  MisalignErr
);

    fetch_state_t          state;
    fetch_state_t          state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [ADDR_WIDTH-1:0] drop_addr;
    logic [ADDR_WIDTH-1:0] target;
    logic                  redirect;
    logic                  misaligned;
    logic                  buf_free;
    logic                  issue_ok;
    logic                  capture;

    always_comb begin
        redirect   = is_redirect(PCSrc);
        target     = (PCSrc == PCSRC_BR) ? BrTarget : AluTarget;
        misaligned = redirect && (target[1:0] != 2'b00);
        buf_free   = !bus.IfValid || bus.IfReady;
        issue_ok   = (PCSrc != PCSRC_NOINC) && buf_free;
        capture    = (state == FETCH_REQ) && bus.IMemAck && !redirect;
    end

    // While a discarded request is still outstanding its address must stay
    // on the bus even though the PC already points at the redirect target.
    assign bus.IMemReq  = (state != FETCH_IDLE);
    assign bus.IMemAddr = (state == FETCH_DROP) ? drop_addr : pc;
    assign Flush        = redirect;

    // Back-to-back fetch only continues if the consumer is draining, since
    // the just-captured word occupies the single buffer entry.
    always_comb begin
        state_next = state;
        pc_next    = pc;

        case (state)
            FETCH_IDLE: begin
                if (redirect || issue_ok) begin
                    state_next = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (bus.IMemAck) begin
                    if (redirect) begin
                        state_next = FETCH_REQ;
                    end else if ((PCSrc == PCSRC_INC) && bus.IfReady) begin
                        state_next = FETCH_REQ;
                    end else begin
                        state_next = FETCH_IDLE;
                    end
                end else if (redirect) begin
                    state_next = FETCH_DROP;
                end
            end
            FETCH_DROP: begin
                if (bus.IMemAck) begin
                    state_next = (redirect || issue_ok) ? FETCH_REQ : FETCH_IDLE;
                end
            end
            default: begin
                state_next = FETCH_IDLE;
            end
        endcase

        if (redirect) begin
            pc_next = {target[ADDR_WIDTH-1:2], 2'b00};
        end else if (capture && (PCSrc == PCSRC_INC)) begin
            pc_next = pc + ADDR_WIDTH'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH_IDLE;
            pc          <= RESET_PC;
            drop_addr   <= RESET_PC;
            MisalignErr <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            MisalignErr <= misaligned;
            if ((state == FETCH_REQ) && !bus.IMemAck && redirect) begin
                drop_addr <= pc;
            end
        end
    end

    if_fetch_unit_buffer #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .INST_WIDTH(INST_WIDTH)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (capture),
        .pop       (bus.IfReady),
        .push_instr(bus.IMemRdata),
        .push_pc   (pc),
        .valid     (bus.IfValid),
        .instr     (bus.IfInstr),
        .pc        (bus.IfPC)
    );

endmodule
